// File: rtl/imem_pkg.sv
// Shared types and defaults for the instruction-memory arbiter.
// Owner tags the single response stage; state_t is the arbiter mode.
package imem_pkg;

  localparam int DEPTH_DEF  = 64;
  localparam int ADDR_W_DEF = 6;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_LOAD  = 1'b1
  } owner_t;

  typedef enum logic {
    RR     = 1'b0,
    LOCKED = 1'b1
  } state_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
    logic   err;
  } rsp_t;

endpackage

// File: rtl/imem_arbiter_if.sv
// Fetch port, loader port and memory port bundled for the arbiter.
// slave is the arbiter side; master is the requesters plus memory.
interface imem_arbiter_if
  import imem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              f_req;
  logic [31:0]       f_addr;
  logic              f_gnt;
  logic              f_rvalid;
  logic [31:0]       f_rdata;
  logic              f_err;

  logic              l_req;
  logic              l_we;
  logic              l_lock;
  logic [31:0]       l_addr;
  logic [31:0]       l_wdata;
  logic              l_gnt;
  logic              l_rvalid;
  logic [31:0]       l_rdata;
  logic              l_err;

  logic              m_en;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [31:0]       m_wdata;
  logic [31:0]       m_rdata;

  modport slave (
    input  f_req, f_addr,
    output f_gnt, f_rvalid, f_rdata, f_err,
    input  l_req, l_we, l_lock, l_addr, l_wdata,
    output l_gnt, l_rvalid, l_rdata, l_err,
    output m_en, m_we, m_addr, m_wdata,
    input  m_rdata
  );

  modport master (
    output f_req, f_addr,
    input  f_gnt, f_rvalid, f_rdata, f_err,
    output l_req, l_we, l_lock, l_addr, l_wdata,
    input  l_gnt, l_rvalid, l_rdata, l_err,
    input  m_en, m_we, m_addr, m_wdata,
    output m_rdata
  );

endinterface

// File: rtl/imem_arbiter_rr_arb2.sv
// Two-way round-robin grant; ptr=1 means req[1] won last time.
// On a tie the port that did not win last is granted.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt    = 2'b00;
    gnt[0] = req[0] & (~req[1] | ptr);
    gnt[1] = req[1] & (~req[0] | ~ptr);
  end

endmodule

// File: rtl/imem_arbiter.sv
// Arbitrates fetch and loader onto one single-port instruction memory.
// Grant and memory controls are combinational; responses lag one cycle.
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input logic           CLK,
  input logic           Reset,
  imem_arbiter_if.slave bus
);

  state_t      state;
  owner_t      last;
  rsp_t        rsp;

  logic [1:0]  rr_gnt;
  logic [1:0]  gnt;
  logic        locked;
  logic        acc;
  logic        sel_l;
  logic        we;
  logic        ok;
  logic [31:0] addr;
  logic        f_hit;
  logic        l_hit;

  rr_arb2 u_rr (
    .req ({bus.l_req, bus.f_req}),
    .ptr (last == OWN_LOAD),
    .gnt (rr_gnt)
  );

  // Lock only holds while l_lock stays high; dropping it reverts to RR now.
  always_comb begin
    locked = (state == LOCKED) && bus.l_lock;
    gnt    = 2'b00;
    if (Reset)
      gnt = locked ? {bus.l_req, 1'b0} : rr_gnt;
    acc   = |gnt;
    sel_l = gnt[1];
    addr  = sel_l ? bus.l_addr : bus.f_addr;
    we    = sel_l & bus.l_we;
    ok    = (addr[1:0] == 2'b00) &&
            ({2'b00, addr[31:2]} < 32'(DEPTH));
  end

  assign bus.f_gnt   = gnt[0];
  assign bus.l_gnt   = gnt[1];
  assign bus.m_en    = acc & ok;
  assign bus.m_we    = acc & ok & we;
  assign bus.m_addr  = addr[ADDR_W+1:2];
  assign bus.m_wdata = sel_l ? bus.l_wdata : '0;

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state <= RR;
      last  <= OWN_LOAD;
      rsp   <= '0;
    end else begin
      rsp.valid <= acc & ~we;
      rsp.owner <= sel_l ? OWN_LOAD : OWN_FETCH;
      rsp.err   <= ~ok;
      if (acc)
        last <= sel_l ? OWN_LOAD : OWN_FETCH;
      unique case (state)
        RR:
          state <= (sel_l && bus.l_lock) ? LOCKED : RR;
        LOCKED:
          state <= bus.l_lock ? LOCKED : RR;
        default:
          state <= RR;
      endcase
    end
  end

  // Masking with Reset kills a response whose cycle overlaps reset.
  assign f_hit = Reset & rsp.valid & (rsp.owner == OWN_FETCH);
  assign l_hit = Reset & rsp.valid & (rsp.owner == OWN_LOAD);

  assign bus.f_rvalid = f_hit;
  assign bus.f_err    = f_hit & rsp.err;
  assign bus.f_rdata  = (f_hit & ~rsp.err) ? bus.m_rdata : '0;

  assign bus.l_rvalid = l_hit;
  assign bus.l_err    = l_hit & rsp.err;
  assign bus.l_rdata  = (l_hit & ~rsp.err) ? bus.m_rdata : '0;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a 64-word memory model.
// Memory word i is preloaded with A0000000+i.
module tb_imem_arbiter;
  import imem_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imem_arbiter_if bus ();

  imem_arbiter dut (
    .CLK   (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  logic [31:0] mem [64];
  logic [31:0] rd = '0;

  initial begin
    for (int i = 0; i < 64; i++)
      mem[i] <= 32'hA000_0000 + 32'(i);
  end

  always @(posedge clk) begin
    if (bus.m_en) begin
      if (bus.m_we) mem[bus.m_addr] <= bus.m_wdata;
      else          rd <= mem[bus.m_addr];
    end
  end

  assign bus.m_rdata = rd;

  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_f(input logic req,
                       input logic [31:0] a);
    bus.f_req  = req;
    bus.f_addr = a;
  endtask

  task automatic set_l(input logic req,
                       input logic w,
                       input logic lk,
                       input logic [31:0] a,
                       input logic [31:0] d);
    bus.l_req   = req;
    bus.l_we    = w;
    bus.l_lock  = lk;
    bus.l_addr  = a;
    bus.l_wdata = d;
  endtask

  initial begin
    set_f(0, 0);
    set_l(0, 0, 0, 0, 0);
    step();

    // reset: no grants, no enable, no response
    rst_n = 0;
    set_f(1, 0);
    set_l(1, 0, 0, 32'h4, 0);
    #1;
    chk("rst_fgnt", 32'(bus.f_gnt), 0);
    chk("rst_lgnt", 32'(bus.l_gnt), 0);
    chk("rst_men",  32'(bus.m_en), 0);
    step();
    chk("rst_frv", 32'(bus.f_rvalid), 0);
    chk("rst_lrv", 32'(bus.l_rvalid), 0);

    // fetch-only back-to-back reads
    rst_n = 1;
    set_l(0, 0, 0, 0, 0);
    set_f(1, 32'h0);
    #1;
    chk("f0_gnt",  32'(bus.f_gnt), 1);
    chk("f0_men",  32'(bus.m_en), 1);
    chk("f0_addr", 32'(bus.m_addr), 0);
    step();
    set_f(1, 32'h4);
    #1;
    chk("f1_gnt",  32'(bus.f_gnt), 1);
    chk("f1_addr", 32'(bus.m_addr), 1);
    chk("f0_rv",   32'(bus.f_rvalid), 1);
    chk("f0_err",  32'(bus.f_err), 0);
    chk("f0_data", bus.f_rdata, 32'hA000_0000);
    step();
    set_f(1, 32'h8);
    #1;
    chk("f2_gnt",  32'(bus.f_gnt), 1);
    chk("f1_rv",   32'(bus.f_rvalid), 1);
    chk("f1_data", bus.f_rdata, 32'hA000_0001);
    step();
    set_f(0, 0);
    #1;
    chk("f2_rv",   32'(bus.f_rvalid), 1);
    chk("f2_data", bus.f_rdata, 32'hA000_0002);
    step();
    chk("f_idle_rv",   32'(bus.f_rvalid), 0);
    chk("f_idle_data", bus.f_rdata, 0);

    // both reading after reset: F, L, F, L
    rst_n = 0;
    step();
    rst_n = 1;
    set_f(1, 32'h20);
    set_l(1, 0, 0, 32'h24, 0);
    #1;
    chk("t1_fgnt", 32'(bus.f_gnt), 1);
    chk("t1_lgnt", 32'(bus.l_gnt), 0);
    chk("t1_addr", 32'(bus.m_addr), 8);
    step();
    chk("t2_lgnt", 32'(bus.l_gnt), 1);
    chk("t2_fgnt", 32'(bus.f_gnt), 0);
    chk("t2_addr", 32'(bus.m_addr), 9);
    chk("t1_frv",  32'(bus.f_rvalid), 1);
    chk("t1_lrv",  32'(bus.l_rvalid), 0);
    chk("t1_data", bus.f_rdata, 32'hA000_0008);
    step();
    chk("t3_fgnt", 32'(bus.f_gnt), 1);
    chk("t2_lrv",  32'(bus.l_rvalid), 1);
    chk("t2_frv",  32'(bus.f_rvalid), 0);
    chk("t2_data", bus.l_rdata, 32'hA000_0009);
    step();
    chk("t4_lgnt", 32'(bus.l_gnt), 1);
    chk("t3_data", bus.f_rdata, 32'hA000_0008);
    step();
    set_f(0, 0);
    set_l(0, 0, 0, 0, 0);
    #1;
    chk("t4_data", bus.l_rdata, 32'hA000_0009);
    step();

    // locked loader write while fetch keeps asking
    set_f(1, 32'h10);
    set_l(1, 1, 1, 32'h10, 32'hDEAD_BEEF);
    #1;
    chk("k1_fgnt", 32'(bus.f_gnt), 1);
    chk("k1_lgnt", 32'(bus.l_gnt), 0);
    step();
    chk("k2_lgnt",  32'(bus.l_gnt), 1);
    chk("k2_fgnt",  32'(bus.f_gnt), 0);
    chk("k2_mwe",   32'(bus.m_we), 1);
    chk("k2_addr",  32'(bus.m_addr), 4);
    chk("k2_wdata", bus.m_wdata, 32'hDEAD_BEEF);
    chk("k1_data",  bus.f_rdata, 32'hA000_0004);
    step();
    chk("k3_fgnt", 32'(bus.f_gnt), 0);
    chk("k3_lgnt", 32'(bus.l_gnt), 1);
    chk("k2_lrv",  32'(bus.l_rvalid), 0);
    step();
    bus.l_req = 0;
    #1;
    chk("k4_fgnt", 32'(bus.f_gnt), 0);
    chk("k4_men",  32'(bus.m_en), 0);
    chk("k3_lrv",  32'(bus.l_rvalid), 0);
    step();
    bus.l_lock = 0;
    #1;
    chk("k5_fgnt", 32'(bus.f_gnt), 1);
    step();
    set_f(0, 0);
    set_l(0, 0, 0, 0, 0);
    #1;
    chk("k5_rv",   32'(bus.f_rvalid), 1);
    chk("k5_data", bus.f_rdata, 32'hDEAD_BEEF);
    step();

    // misaligned, out of range, last valid word
    set_f(1, 32'h102);
    #1;
    chk("e1_fgnt", 32'(bus.f_gnt), 1);
    chk("e1_men",  32'(bus.m_en), 0);
    step();
    set_f(1, 32'h100);
    #1;
    chk("e2_fgnt", 32'(bus.f_gnt), 1);
    chk("e2_men",  32'(bus.m_en), 0);
    chk("e1_rv",   32'(bus.f_rvalid), 1);
    chk("e1_err",  32'(bus.f_err), 1);
    chk("e1_data", bus.f_rdata, 0);
    step();
    set_f(1, 32'hFC);
    #1;
    chk("e3_men",  32'(bus.m_en), 1);
    chk("e3_addr", 32'(bus.m_addr), 63);
    chk("e2_rv",   32'(bus.f_rvalid), 1);
    chk("e2_err",  32'(bus.f_err), 1);
    step();
    set_f(0, 0);
    set_l(1, 1, 0, 32'h101, 32'h55);
    #1;
    chk("e3_err",  32'(bus.f_err), 0);
    chk("e3_data", bus.f_rdata, 32'hA000_003F);
    chk("e4_lgnt", 32'(bus.l_gnt), 1);
    chk("e4_men",  32'(bus.m_en), 0);
    step();
    set_l(1, 0, 0, 32'h200, 0);
    #1;
    chk("e4_lrv",  32'(bus.l_rvalid), 0);
    chk("e5_lgnt", 32'(bus.l_gnt), 1);
    chk("e5_men",  32'(bus.m_en), 0);
    step();
    set_l(0, 0, 0, 0, 0);
    #1;
    chk("e5_lrv",  32'(bus.l_rvalid), 1);
    chk("e5_err",  32'(bus.l_err), 1);
    chk("e5_data", bus.l_rdata, 0);
    step();

    // reset right after a fetch accept
    set_f(1, 32'h0);
    #1;
    chk("r1_fgnt", 32'(bus.f_gnt), 1);
    step();
    rst_n = 0;
    #1;
    chk("r1_rv",   32'(bus.f_rvalid), 0);
    chk("r2_fgnt", 32'(bus.f_gnt), 0);
    step();
    chk("r2_rv", 32'(bus.f_rvalid), 0);
    rst_n = 1;
    set_f(1, 32'h4);
    set_l(1, 0, 0, 32'h8, 0);
    #1;
    chk("r3_fgnt", 32'(bus.f_gnt), 1);
    chk("r3_lgnt", 32'(bus.l_gnt), 0);
    step();
    set_f(0, 0);
    set_l(0, 0, 0, 0, 0);
    #1;
    chk("r3_rv",   32'(bus.f_rvalid), 1);
    chk("r3_data", bus.f_rdata, 32'hA000_0001);
    step();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
